rd_writeback_controller: RTL and testbench

- Sequences the register-file writeback path for the core.
- Accepts one decoded writeback request per cycle: source select plus destination register.
- Drives exactly one of the four rd-source enables (memory, ALU, immediate former, branch ALU), together with rd_write_enable and rd_address.
- Inserts wait states for memory loads and counts committed writebacks.

---
 rtl/rd_writeback_controller.sv | 174 +++++++++++++++++
 tb/tb_rd_writeback_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_writeback_controller.sv
// rd_writeback_controller
//
// Sequences the register-file writeback path. Each accepted request selects one
// of four rd sources (memory, ALU, immediate former, branch ALU) and a
// destination register. Non-memory sources, and memory when MEM_LATENCY is 1,
// write back on the cycle after the accept. Memory loads with a longer latency
// wait in a pending state until their data is due. Committed writes are counted.
//
// Parameters:
//   MEM_LATENCY  cycles from a memory accept to its writeback cycle (1..8)
//   COUNT_WIDTH  width of the committed-writeback counter
//
// Ports:
//   clock                 rising-edge clock
//   reset                 synchronous, active-high reset
//   issue_valid           writeback request present
//   issue_ready           request can be accepted this cycle
//   issue_source          0=memory, 1=ALU, 2=immediate former, 3=branch ALU
//   issue_rd_addr         destination register index
//   flush                 cancel a pending memory writeback, block acceptance
//   mem_output_enable     select memory output onto rd
//   alu_output_enable     select ALU output onto rd
//   imm_output_enable     select immediate former output onto rd
//   branch_output_enable  select branch ALU output onto rd
//   rd_write_enable       register file write strobe
//   rd_address            register file write index
//   busy                  memory writeback pending
//   writeback_count       number of committed writes (wraps)

module rd_writeback_controller #(
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic [1:0]             issue_source,
  input  logic [4:0]             issue_rd_addr,
  input  logic                   flush,
  output logic                   mem_output_enable,
  output logic                   alu_output_enable,
  output logic                   imm_output_enable,
  output logic                   branch_output_enable,
  output logic                   rd_write_enable,
  output logic [4:0]             rd_address,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] writeback_count
);

  typedef enum logic [1:0] {
    StIdle,
    StMemWait,
    StWrite
  } state_e;

  typedef enum logic [1:0] {
    SrcMem    = 2'd0,
    SrcAlu    = 2'd1,
    SrcImm    = 2'd2,
    SrcBranch = 2'd3
  } src_e;

  // A single-cycle memory latency needs no wait state at all.
  localparam bit MemDirect = (MEM_LATENCY <= 1);
  // The accept edge and the final MEM_WAIT -> WRITE edge account for two of the
  // MEM_LATENCY cycles, so the down-counter starts at MEM_LATENCY-2.
  localparam logic [2:0] WaitInit = MemDirect ? 3'd0 : 3'(MEM_LATENCY - 2);

  state_e                 state_q;
  logic [2:0]             wait_cnt_q;
  logic [4:0]             pend_addr_q;
  logic                   mem_en_q;
  logic                   alu_en_q;
  logic                   imm_en_q;
  logic                   br_en_q;
  logic                   we_q;
  logic [4:0]             addr_q;
  logic                   busy_q;
  logic [COUNT_WIDTH-1:0] count_q;

  src_e issue_src;
  logic accept;
  logic issue_to_wait;

  assign issue_src     = src_e'(issue_source);
  assign issue_ready   = !reset && !flush && (state_q != StMemWait);
  assign accept        = issue_valid && issue_ready;
  assign issue_to_wait = (issue_src == SrcMem) && !MemDirect;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      wait_cnt_q  <= '0;
      pend_addr_q <= '0;
      mem_en_q    <= 1'b0;
      alu_en_q    <= 1'b0;
      imm_en_q    <= 1'b0;
      br_en_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      busy_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      // Enables and the strobe are single-cycle pulses; only WRITE entry sets them.
      mem_en_q <= 1'b0;
      alu_en_q <= 1'b0;
      imm_en_q <= 1'b0;
      br_en_q  <= 1'b0;
      we_q     <= 1'b0;

      if (we_q) begin
        count_q <= count_q + COUNT_WIDTH'(1);
      end

      unique case (state_q)
        StIdle, StWrite: begin
          if (accept) begin
            if (issue_to_wait) begin
              state_q     <= StMemWait;
              wait_cnt_q  <= WaitInit;
              pend_addr_q <= issue_rd_addr;
              busy_q      <= 1'b1;
            end else begin
              state_q <= StWrite;
              addr_q  <= issue_rd_addr;
              // x0 still pulses its source enable but never strobes the file.
              we_q    <= (issue_rd_addr != 5'd0);
              unique case (issue_src)
                SrcMem:    mem_en_q <= 1'b1;
                SrcAlu:    alu_en_q <= 1'b1;
                SrcImm:    imm_en_q <= 1'b1;
                SrcBranch: br_en_q  <= 1'b1;
              endcase
            end
          end else begin
            state_q <= StIdle;
          end
        end

        StMemWait: begin
          // flush has priority even on the cycle the wait expires.
          if (flush) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (wait_cnt_q == 3'd0) begin
            state_q  <= StWrite;
            mem_en_q <= 1'b1;
            addr_q   <= pend_addr_q;
            we_q     <= (pend_addr_q != 5'd0);
            busy_q   <= 1'b0;
          end else begin
            wait_cnt_q <= wait_cnt_q - 3'd1;
          end
        end

        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_output_enable    = mem_en_q;
  assign alu_output_enable    = alu_en_q;
  assign imm_output_enable    = imm_en_q;
  assign branch_output_enable = br_en_q;
  assign rd_write_enable      = we_q;
  assign rd_address           = addr_q;
  assign busy                 = busy_q;
  assign writeback_count      = count_q;

endmodule

// File: tb/tb_rd_writeback_controller.sv
// Bench for rd_writeback_controller. A predictor turns each accepted request
// into an expected writeback (cycle, source, register) and pushes it onto a
// scoreboard queue; a separate monitor compares every DUT output cycle
// against the queue and an abstract count / last-address model.

module tb_rd_writeback_controller;

  localparam int unsigned MemLat = 3;
  localparam int unsigned CntW   = 4;

  logic            clock;
  logic            reset;
  logic            issue_valid;
  logic            issue_ready;
  logic [1:0]      issue_source;
  logic [4:0]      issue_rd_addr;
  logic            flush;
  logic            mem_output_enable;
  logic            alu_output_enable;
  logic            imm_output_enable;
  logic            branch_output_enable;
  logic            rd_write_enable;
  logic [4:0]      rd_address;
  logic            busy;
  logic [CntW-1:0] writeback_count;

  rd_writeback_controller #(
    .MEM_LATENCY(MemLat),
    .COUNT_WIDTH(CntW)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .issue_valid         (issue_valid),
    .issue_ready         (issue_ready),
    .issue_source        (issue_source),
    .issue_rd_addr       (issue_rd_addr),
    .flush               (flush),
    .mem_output_enable   (mem_output_enable),
    .alu_output_enable   (alu_output_enable),
    .imm_output_enable   (imm_output_enable),
    .branch_output_enable(branch_output_enable),
    .rd_write_enable     (rd_write_enable),
    .rd_address          (rd_address),
    .busy                (busy),
    .writeback_count     (writeback_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int         due;
    logic [1:0] src;
    logic [4:0] addr;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic started = 1'b0;

  // Predictor outputs for the current cycle, consumed by the monitor.
  logic exp_ready = 1'b0;
  logic exp_busy  = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  // Predictor: a load is outstanding from its accept until its due cycle.
  initial begin : predictor
    bit mem_pend;
    int mem_due;
    mem_pend = 1'b0;
    mem_due  = 0;
    wait (started);
    forever begin
      @(negedge clock);
      if (mem_pend && cyc >= mem_due) mem_pend = 1'b0;
      exp_busy  = mem_pend;
      exp_ready = !reset && !flush && !mem_pend;
      if (reset) begin
        while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
        mem_pend = 1'b0;
      end else if (mem_pend && flush) begin
        while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
        mem_pend = 1'b0;
      end else if (issue_valid && exp_ready) begin
        exp_t e;
        int   lat;
        lat    = (issue_source == 2'd0) ? int'(MemLat) : 1;
        e.due  = cyc + lat;
        e.src  = issue_source;
        e.addr = issue_rd_addr;
        sb.push_back(e);
        if (lat > 1) begin
          mem_pend = 1'b1;
          mem_due  = e.due;
        end
      end
    end
  end

  // Monitor: compares everything the DUT shows this cycle.
  initial begin : monitor
    int         exp_count;
    logic [4:0] exp_last;
    exp_count = 0;
    exp_last  = 5'd0;
    wait (started);
    forever begin
      logic [3:0] en;
      bit         wrote;
      @(negedge clock);
      #1;
      en    = {branch_output_enable, imm_output_enable, alu_output_enable, mem_output_enable};
      wrote = 1'b0;
      check("one_hot", 32'($countones(en) <= 1), 32'd1);
      check("issue_ready", 32'(issue_ready), 32'(exp_ready));
      check("busy", 32'(busy), 32'(exp_busy));
      check("writeback_count", 32'(writeback_count), 32'(exp_count));
      if (en != 4'd0) begin
        if (sb.size() == 0 || sb[0].due != cyc) begin
          check("unexpected_writeback", 32'(en), 32'd0);
        end else begin
          exp_t       e;
          logic [3:0] exp_en;
          e      = sb.pop_front();
          exp_en = 4'd1 << e.src;
          check("source_enable", 32'(en), 32'(exp_en));
          check("rd_address", 32'(rd_address), 32'(e.addr));
          check("rd_write_enable", 32'(rd_write_enable), 32'(e.addr != 5'd0));
          exp_last = e.addr;
          wrote    = (e.addr != 5'd0);
        end
      end else begin
        check("idle_write_enable", 32'(rd_write_enable), 32'd0);
        check("idle_rd_address", 32'(rd_address), 32'(exp_last));
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          check("missing_writeback", 32'd0, 32'(sb[0].addr) | 32'h100);
          void'(sb.pop_front());
        end
      end
      if (reset) begin
        exp_count = 0;
        exp_last  = 5'd0;
      end else if (wrote) begin
        exp_count = (exp_count + 1) % (1 << CntW);
      end
    end
  end

  // Drive one cycle's inputs, then advance past the next rising edge.
  task automatic step(input logic v, input logic [1:0] s, input logic [4:0] a,
                      input logic f, input logic r);
    issue_valid   = v;
    issue_source  = s;
    issue_rd_addr = a;
    flush         = f;
    reset         = r;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin : stimulus
    issue_valid   = 1'b0;
    issue_source  = 2'd0;
    issue_rd_addr = 5'd0;
    flush         = 1'b0;
    reset         = 1'b1;
    @(posedge clock);
    #1;
    started = 1'b1;
    step(1'b0, 2'd0, 5'd0, 1'b0, 1'b1);
    idle(2);

    // ALU to x5.
    step(1'b1, 2'd1, 5'd5, 1'b0, 1'b0);
    idle(2);
    // Memory load to x7.
    step(1'b1, 2'd0, 5'd7, 1'b0, 1'b0);
    idle(4);
    // Back-to-back immediate x1, branch x2, ALU x3.
    step(1'b1, 2'd2, 5'd1, 1'b0, 1'b0);
    step(1'b1, 2'd3, 5'd2, 1'b0, 1'b0);
    step(1'b1, 2'd1, 5'd3, 1'b0, 1'b0);
    idle(2);
    // Immediate to x0.
    step(1'b1, 2'd2, 5'd0, 1'b0, 1'b0);
    idle(2);
    // Load then flush on the cycle the wait expires.
    step(1'b1, 2'd0, 5'd9, 1'b0, 1'b0);
    step(1'b0, 2'd0, 5'd0, 1'b0, 1'b0);
    step(1'b0, 2'd0, 5'd0, 1'b1, 1'b0);
    idle(3);
    // Load then flush in the first wait cycle, with a blocked request alongside.
    step(1'b1, 2'd0, 5'd10, 1'b0, 1'b0);
    step(1'b1, 2'd1, 5'd11, 1'b1, 1'b0);
    idle(3);
    // Reset during MEM_WAIT.
    step(1'b1, 2'd0, 5'd12, 1'b0, 1'b0);
    step(1'b0, 2'd0, 5'd0, 1'b0, 1'b1);
    idle(4);
    // Reset during a WRITE cycle.
    step(1'b1, 2'd1, 5'd13, 1'b0, 1'b0);
    step(1'b1, 2'd2, 5'd14, 1'b0, 1'b1);
    idle(2);
    // Sixteen ALU writes wrap the 4-bit counter back to its start.
    for (int i = 0; i < 16; i++) step(1'b1, 2'd1, 5'(i % 31 + 1), 1'b0, 1'b0);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic       v;
      logic [1:0] s;
      logic [4:0] a;
      logic       f;
      logic       r;
      v = ($urandom_range(0, 99) < 70);
      s = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 99) < 15) ? 5'd0 : 5'($urandom_range(1, 31));
      f = ($urandom_range(0, 99) < 10);
      r = ($urandom_range(0, 99) < 2);
      step(v, s, a, f, r);
    end

    idle(12);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
